ls_port_arbiter: RTL
====================

# ls_port_arbiter

Arbitrates the single LocalStore port between three requesters: the odd-pipe load/store unit, the instruction-fetch unit and the preload/DMA engine. It accepts at most one quadword access per cycle and drives the LocalStore command registers. It returns read data to the owning requester with a fixed latency. It sits between the odd pipe's LS address stage and the LocalStore macro, and raises a stall to the odd pipe when the pipe loses arbitration.

## Interface
- ADDR_W, 15, LocalStore byte-address width
- DATA_W, 128, quadword width
- STARVE_LIMIT, 8, consecutive denied cycles before a non-pipe requester is promoted (used only with the guard macro)

- clk  in  1  clock; all logic on the rising edge
- rst  in  1  reset; synchronous, active-low (0 = reset)
- pipe_req_valid / pipe_req_we  in  1 / 1  odd-pipe request; we=1 is a store (stqa/stqd), we=0 is a load
- pipe_req_addr / pipe_req_wdata  in  ADDR_W / DATA_W  odd-pipe address and store data
- pipe_req_ready  out  1  odd-pipe request accepted this cycle
- pipe_rsp_valid / pipe_rsp_data  out  1 / DATA_W  odd-pipe load return
- if_req_valid / if_req_addr  in  1 / ADDR_W  fetch read request (read-only)
- if_req_ready / if_rsp_valid / if_rsp_data  out  1 / 1 / DATA_W  fetch accept and return
- dma_req_valid / dma_req_we / dma_req_addr / dma_req_wdata  in  1 / 1 / ADDR_W / DATA_W  preload/DMA request
- dma_req_ready / dma_rsp_valid / dma_rsp_data  out  1 / 1 / DATA_W  DMA accept and return
- ls_en / ls_we  out  1 / 1  LocalStore command strobe and write enable
- ls_addr / ls_wdata  out  ADDR_W / DATA_W  LocalStore address (quadword-aligned) and write data
- ls_rdata  in  DATA_W  LocalStore read data, valid one cycle after ls_en with ls_we=0
- stall_pipe  out  1  pipe_req_valid and not pipe_req_ready

## Operation
- Handshake per requester:
  - A request transfers when valid and ready are both 1 in the same cycle.
  - The ready outputs are combinational from the valids and the arbiter state.
  - Exactly one ready is high per cycle, and only when its valid is high.
  - A requester holds valid, address and data stable until it sees ready.
- Base priority is fixed: pipe > fetch > DMA.
- Address alignment: the low 4 address bits are ignored. ls_addr carries the request address with its low 4 bits forced to 0.
- Command stage (registered):
  - On a transfer, ls_en=1, ls_we, ls_addr and ls_wdata are loaded from the winner.
  - A 2-bit owner tag is loaded alongside: 1 = pipe, 2 = fetch, 3 = DMA.
  - With no transfer, ls_en=0 and ls_we=0. ls_addr and ls_wdata hold their last values.
- Return stage (registered):
  - A read command (ls_en=1, ls_we=0) forwards its owner tag into a return register.
  - The next cycle, the owner's rsp_valid=1 with rsp_data=ls_rdata.
  - The other two rsp_valid outputs are 0.
  - Stores produce no response.
- rsp_data for non-owners holds its last value, so it is only meaningful while rsp_valid is 1.
- Ordering: accesses reach the LocalStore in acceptance order. A store followed by a load to the same quadword returns the new data.
- Reset (rst=0 at a clock edge):
  - All readys, rsp_valids, ls_en, ls_we and stall_pipe go to 0.
  - ls_addr, ls_wdata and rsp_data go to 0.
  - Owner tags clear, and starvation counters clear.
  - In-flight reads are discarded; no rsp_valid is issued after reset deasserts.
  - The readys are forced to 0 for as long as rst=0.

## Timing
- Request accepted in cycle N → ls_en in cycle N+1 → rsp_valid with data in cycle N+2. Read latency is fixed at 2.
- Throughput is one access per cycle. Back-to-back reads from different owners return in order, one per cycle.
- stall_pipe is combinational and valid in the same cycle as pipe_req_valid.
- No state machine beyond the 2-deep tag pipeline and, when enabled, the starvation counters.

## Configuration
- Macro: LS_ARB_STARVE_GUARD_EN
- Defined:
  - Per-requester saturating counters for fetch and DMA, each clog2(STARVE_LIMIT+1) bits.
  - A counter increments each cycle its requester has valid=1 and ready=0.
  - It clears on that requester's transfer, or on any cycle its valid=0.
  - When a counter equals STARVE_LIMIT, that requester is promoted. Priority becomes starving fetch > starving DMA > pipe > fetch > DMA.
  - The pipe therefore stalls for at most one cycle per promotion.
- Undefined:
  - No counters exist and priority is strict pipe > fetch > DMA.
  - Fetch and DMA can starve indefinitely.
  - STARVE_LIMIT is ignored.

## Test plan
- Reset: hold rst=0 for 3 cycles with all valids=1 → all readys, ls_en and rsp_valids are 0. After release, pipe_req_ready=1 on the first cycle.
- Simultaneous read requests: pipe, fetch and DMA all present reads at 0x0010, 0x0020 and 0x0030 with LocalStore preloaded 0xA, 0xB, 0xC.
  - Grants follow pipe, fetch, DMA on consecutive cycles.
  - The responses return 0xA, 0xB, 0xC to the respective owners, each exactly 2 cycles after its grant.
- Store then load: pipe stores 0x1234 at 0x0045 in cycle N, then loads 0x0040 in cycle N+1.
  - ls_addr=0x0040 both times.
  - pipe_rsp_data=0x1234 in cycle N+3.
- Stall: pipe and fetch valid in the same cycle → pipe wins and fetch gets ready=0. Then fetch alone is valid → fetch wins and stall_pipe stays 0 throughout.
- Starvation (macro defined, STARVE_LIMIT=8): pipe valid every cycle and DMA valid continuously → DMA is granted on the 9th cycle, and stall_pipe=1 in that cycle only. With the macro undefined, DMA is never granted.
- Reset mid-read: pull rst=0 in the cycle after a fetch grant → if_rsp_valid never asserts for that request.

Source files
------------

// File: rtl/ls_port_arbiter_if.sv
// ls_port_arbiter_if
// Bundles the three requester handshakes, the LocalStore command/read-data
// signals and the odd-pipe stall into a single connection.
//   master : requester / LocalStore side (drives valids, addresses, wdata, ls_rdata)
//   slave  : arbiter side (drives readys, responses, LocalStore command, stall_pipe)
interface ls_port_arbiter_if #(
   parameter int unsigned ADDR_W = 15,
   parameter int unsigned DATA_W = 128
);
   // odd-pipe load/store unit
   logic              pipe_req_valid;
   logic              pipe_req_we;
   logic [ADDR_W-1:0] pipe_req_addr;
   logic [DATA_W-1:0] pipe_req_wdata;
   logic              pipe_req_ready;
   logic              pipe_rsp_valid;
   logic [DATA_W-1:0] pipe_rsp_data;
   // instruction fetch (read-only)
   logic              if_req_valid;
   logic [ADDR_W-1:0] if_req_addr;
   logic              if_req_ready;
   logic              if_rsp_valid;
   logic [DATA_W-1:0] if_rsp_data;
   // preload / DMA engine
   logic              dma_req_valid;
   logic              dma_req_we;
   logic [ADDR_W-1:0] dma_req_addr;
   logic [DATA_W-1:0] dma_req_wdata;
   logic              dma_req_ready;
   logic              dma_rsp_valid;
   logic [DATA_W-1:0] dma_rsp_data;
   // LocalStore macro
   logic              ls_en;
   logic              ls_we;
   logic [ADDR_W-1:0] ls_addr;
   logic [DATA_W-1:0] ls_wdata;
   logic [DATA_W-1:0] ls_rdata;
   // odd-pipe stall
   logic              stall_pipe;

   modport master (
      output pipe_req_valid, pipe_req_we, pipe_req_addr, pipe_req_wdata,
      input  pipe_req_ready, pipe_rsp_valid, pipe_rsp_data,
      output if_req_valid, if_req_addr,
      input  if_req_ready, if_rsp_valid, if_rsp_data,
      output dma_req_valid, dma_req_we, dma_req_addr, dma_req_wdata,
      input  dma_req_ready, dma_rsp_valid, dma_rsp_data,
      input  ls_en, ls_we, ls_addr, ls_wdata,
      output ls_rdata,
      input  stall_pipe
   );

   modport slave (
      input  pipe_req_valid, pipe_req_we, pipe_req_addr, pipe_req_wdata,
      output pipe_req_ready, pipe_rsp_valid, pipe_rsp_data,
      input  if_req_valid, if_req_addr,
      output if_req_ready, if_rsp_valid, if_rsp_data,
      input  dma_req_valid, dma_req_we, dma_req_addr, dma_req_wdata,
      output dma_req_ready, dma_rsp_valid, dma_rsp_data,
      output ls_en, ls_we, ls_addr, ls_wdata,
      input  ls_rdata,
      output stall_pipe
   );
endinterface

// File: rtl/ls_port_arbiter.sv
// ls_port_arbiter
// Arbitrates the single LocalStore port between the odd pipe, instruction
// fetch and the preload/DMA engine. One quadword access per cycle; read data
// returns to the owner with a fixed latency of 2 (grant -> ls_en -> rsp).
// Ports:
//   i_clk  : clock, rising edge
//   i_rst  : synchronous reset, active-low
//   io_bus : ls_port_arbiter_if.slave (requester handshakes, LocalStore
//            command/read data, stall_pipe)
// Optional feature macro: LS_ARB_STARVE_GUARD_EN
//   Defined  : fetch/DMA starvation counters promote a requester denied for
//              STARVE_LIMIT consecutive cycles above the pipe.
//   Undefined: strict priority pipe > fetch > DMA.
module ls_port_arbiter #(
   parameter int unsigned ADDR_W       = 15,
   parameter int unsigned DATA_W       = 128,
   parameter int unsigned STARVE_LIMIT = 8
) (
   input logic               i_clk,
   input logic               i_rst,
   ls_port_arbiter_if.slave  io_bus
);
   localparam logic [1:0] TagNone  = 2'd0;
   localparam logic [1:0] TagPipe  = 2'd1;
   localparam logic [1:0] TagFetch = 2'd2;
   localparam logic [1:0] TagDma   = 2'd3;
   localparam logic [ADDR_W-1:0] QwMask = ~ADDR_W'(15);

   logic              w_pipe_gnt, w_if_gnt, w_dma_gnt, w_any_gnt;
   logic [1:0]        w_gnt_tag;
   logic              w_gnt_we;
   logic [ADDR_W-1:0] w_gnt_addr;
   logic [DATA_W-1:0] w_gnt_wdata;

   logic              r_ls_en, r_ls_we;
   logic [ADDR_W-1:0] r_ls_addr;
   logic [DATA_W-1:0] r_ls_wdata;
   logic [1:0]        r_cmd_tag, r_rsp_tag;
   logic [DATA_W-1:0] r_pipe_hold, r_if_hold, r_dma_hold;

`ifdef LS_ARB_STARVE_GUARD_EN
   localparam int unsigned CntW = (STARVE_LIMIT == 0) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIMIT);

   logic [CntW-1:0] r_if_cnt, r_dma_cnt;
   logic            w_if_starve, w_dma_starve;

   assign w_if_starve  = io_bus.if_req_valid  && (r_if_cnt == CntMax);
   assign w_dma_starve = io_bus.dma_req_valid && (r_dma_cnt == CntMax);

   always_comb begin
      w_pipe_gnt = 1'b0;
      w_if_gnt   = 1'b0;
      w_dma_gnt  = 1'b0;
      if (i_rst) begin
         if (w_if_starve)                w_if_gnt   = 1'b1;
         else if (w_dma_starve)          w_dma_gnt  = 1'b1;
         else if (io_bus.pipe_req_valid) w_pipe_gnt = 1'b1;
         else if (io_bus.if_req_valid)   w_if_gnt   = 1'b1;
         else if (io_bus.dma_req_valid)  w_dma_gnt  = 1'b1;
      end
   end

   // Saturating denied-cycle counters; any idle cycle or grant restarts them.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_if_cnt  <= '0;
         r_dma_cnt <= '0;
      end else begin
         if (!io_bus.if_req_valid || w_if_gnt) r_if_cnt <= '0;
         else if (r_if_cnt != CntMax)         r_if_cnt <= r_if_cnt + 1'b1;
         if (!io_bus.dma_req_valid || w_dma_gnt) r_dma_cnt <= '0;
         else if (r_dma_cnt != CntMax)          r_dma_cnt <= r_dma_cnt + 1'b1;
      end
   end
`else
   always_comb begin
      w_pipe_gnt = 1'b0;
      w_if_gnt   = 1'b0;
      w_dma_gnt  = 1'b0;
      if (i_rst) begin
         if (io_bus.pipe_req_valid)     w_pipe_gnt = 1'b1;
         else if (io_bus.if_req_valid)  w_if_gnt   = 1'b1;
         else if (io_bus.dma_req_valid) w_dma_gnt  = 1'b1;
      end
   end
`endif

   assign w_any_gnt = w_pipe_gnt | w_if_gnt | w_dma_gnt;

   // Winner's command fields; grants are one-hot by construction.
   always_comb begin
      w_gnt_tag   = TagNone;
      w_gnt_we    = 1'b0;
      w_gnt_addr  = '0;
      w_gnt_wdata = '0;
      unique case (1'b1)
         w_pipe_gnt: begin
            w_gnt_tag   = TagPipe;
            w_gnt_we    = io_bus.pipe_req_we;
            w_gnt_addr  = io_bus.pipe_req_addr;
            w_gnt_wdata = io_bus.pipe_req_wdata;
         end
         w_if_gnt: begin
            w_gnt_tag  = TagFetch;
            w_gnt_addr = io_bus.if_req_addr;
         end
         w_dma_gnt: begin
            w_gnt_tag   = TagDma;
            w_gnt_we    = io_bus.dma_req_we;
            w_gnt_addr  = io_bus.dma_req_addr;
            w_gnt_wdata = io_bus.dma_req_wdata;
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_ls_en     <= 1'b0;
         r_ls_we     <= 1'b0;
         r_ls_addr   <= '0;
         r_ls_wdata  <= '0;
         r_cmd_tag   <= TagNone;
         r_rsp_tag   <= TagNone;
         r_pipe_hold <= '0;
         r_if_hold   <= '0;
         r_dma_hold  <= '0;
      end else begin
         r_ls_en   <= w_any_gnt;
         r_ls_we   <= w_any_gnt & w_gnt_we;
         r_cmd_tag <= w_gnt_tag;
         if (w_any_gnt) begin
            r_ls_addr  <= w_gnt_addr & QwMask;
            r_ls_wdata <= w_gnt_wdata;
         end
         // Only reads advance into the return stage; stores get no response.
         r_rsp_tag <= (r_ls_en && !r_ls_we) ? r_cmd_tag : TagNone;
         // Capture the returned quadword so rsp_data holds once rsp_valid drops.
         if (r_rsp_tag == TagPipe)  r_pipe_hold <= io_bus.ls_rdata;
         if (r_rsp_tag == TagFetch) r_if_hold   <= io_bus.ls_rdata;
         if (r_rsp_tag == TagDma)   r_dma_hold  <= io_bus.ls_rdata;
      end
   end

   assign io_bus.pipe_req_ready = w_pipe_gnt;
   assign io_bus.if_req_ready   = w_if_gnt;
   assign io_bus.dma_req_ready  = w_dma_gnt;
   assign io_bus.stall_pipe     = i_rst & io_bus.pipe_req_valid & ~w_pipe_gnt;

   assign io_bus.ls_en    = r_ls_en;
   assign io_bus.ls_we    = r_ls_we;
   assign io_bus.ls_addr  = r_ls_addr;
   assign io_bus.ls_wdata = r_ls_wdata;

   assign io_bus.pipe_rsp_valid = (r_rsp_tag == TagPipe);
   assign io_bus.if_rsp_valid   = (r_rsp_tag == TagFetch);
   assign io_bus.dma_rsp_valid  = (r_rsp_tag == TagDma);
   assign io_bus.pipe_rsp_data  = (r_rsp_tag == TagPipe)  ? io_bus.ls_rdata : r_pipe_hold;
   assign io_bus.if_rsp_data    = (r_rsp_tag == TagFetch) ? io_bus.ls_rdata : r_if_hold;
   assign io_bus.dma_rsp_data   = (r_rsp_tag == TagDma)   ? io_bus.ls_rdata : r_dma_hold;
endmodule
